// File: rtl/battleship_keys_pkg.sv
// Shared scan-code constants, FSM encoding and key decode for the Battleship target entry.
package battleship_keys_pkg;

    localparam int COORD_W = 4;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] ENTER = 8'h5A;
    localparam logic [7:0] BKSP  = 8'h66;
    localparam logic [7:0] ESC   = 8'h76;

    // Index n holds the scan code for row letter n (A..J) / column digit n (0..9).
    localparam logic [9:0][7:0] LETTER_CODES = {8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B,
                                                8'h24, 8'h23, 8'h21, 8'h32, 8'h1C};
    localparam logic [9:0][7:0] DIGIT_CODES  = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                                8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        ARMED,
        FIRE
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_LETTER,
        KEY_DIGIT,
        KEY_ENTER,
        KEY_BKSP,
        KEY_ESC
    } key_class_e;

    typedef struct packed {
        key_class_e           cls;
        logic [COORD_W-1:0]   val;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k.cls = KEY_NONE;
        k.val = '0;
        for (int i = 0; i < 10; i++) begin
            if (code == LETTER_CODES[i]) begin
                k.cls = KEY_LETTER;
                k.val = COORD_W'(i);
            end
            if (code == DIGIT_CODES[i]) begin
                k.cls = KEY_DIGIT;
                k.val = COORD_W'(i);
            end
        end
        if (code == ENTER) k.cls = KEY_ENTER;
        if (code == BKSP)  k.cls = KEY_BKSP;
        if (code == ESC)   k.cls = KEY_ESC;
        return k;
    endfunction

endpackage

// File: rtl/ps2_word_sync.sv
// Synchronises and debounces the receiver's scan-code window, emitting one pulse per completed key release.
module ps2_word_sync
    import battleship_keys_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keycode,
    output logic        rel_valid,
    output logic [7:0]  rel_code
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] synced;
    logic [31:0] prev_q;
    logic [31:0] last_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        armed_q;
    logic        differs;
    logic        accept;
    logic        rel_valid_q;
    logic [7:0]  rel_code_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= keycode;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A word is accepted on the single edge where its run length reaches STABLE.
    always_comb begin
        differs = (synced != prev_q);
        cnt_d   = cnt_q;
        if (differs)
            cnt_d = 4'd1;
        else if (cnt_q != STABLE)
            cnt_d = cnt_q + 4'd1;
        accept = (cnt_d == STABLE) && ((cnt_q != STABLE) || differs);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q      <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_code_q  <= '0;
        end else begin
            prev_q      <= synced;
            cnt_q       <= cnt_d;
            rel_valid_q <= accept && armed_q && (synced != last_q) && (synced[15:8] == BREAK);
            rel_code_q  <= synced[7:0];
            if (accept) begin
                last_q  <= synced;
                armed_q <= 1'b1;
            end
        end
    end

    assign rel_valid = rel_valid_q;
    assign rel_code  = rel_code_q;

endmodule

// File: rtl/ps2_target_entry.sv
// Turns PS/2 key releases into a Battleship target (row letter, column digit, Enter) offered via valid/ready.
module ps2_target_entry
    import battleship_keys_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        keycode,
    input  logic               fire_ready,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               row_set,
    output logic               col_set,
    output logic               fire_valid,
    output logic               bad_key
);

    logic               rel_valid;
    logic [7:0]         rel_code;
    key_t               key;
    state_e             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic               row_set_q, row_set_d, col_set_q, col_set_d;
    logic               bad_key_q, bad_key_d;

    ps2_word_sync #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .keycode   (keycode),
        .rel_valid (rel_valid),
        .rel_code  (rel_code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            row_set_q <= 1'b0;
            col_set_q <= 1'b0;
            bad_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            row_set_q <= row_set_d;
            col_set_q <= col_set_d;
            bad_key_q <= bad_key_d;
        end
    end

    // While a shot is pending, key events are dropped so the offered coordinate cannot move.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        row_set_d = row_set_q;
        col_set_d = col_set_q;
        bad_key_d = 1'b0;
        key       = decode_key(rel_code);
        if (state_q == FIRE) begin
            if (fire_ready) begin
                state_d   = IDLE;
                row_set_d = 1'b0;
                col_set_d = 1'b0;
            end
        end else if (rel_valid) begin
            case (key.cls)
                KEY_LETTER: begin
                    row_d     = key.val;
                    row_set_d = 1'b1;
                    if (state_q == IDLE) state_d = ROW;
                end
                KEY_DIGIT: begin
                    if (state_q != IDLE) begin
                        col_d     = key.val;
                        col_set_d = 1'b1;
                        state_d   = ARMED;
                    end
                end
                KEY_ENTER: begin
                    if (state_q == ARMED) state_d = FIRE;
                end
                KEY_BKSP: begin
                    if (state_q == ROW) begin
                        row_set_d = 1'b0;
                        state_d   = IDLE;
                    end else if (state_q == ARMED) begin
                        col_set_d = 1'b0;
                        state_d   = ROW;
                    end
                end
                KEY_ESC: begin
                    row_set_d = 1'b0;
                    col_set_d = 1'b0;
                    state_d   = IDLE;
                end
                default: bad_key_d = 1'b1;
            endcase
        end
    end

    assign row        = row_q;
    assign col        = col_q;
    assign row_set    = row_set_q;
    assign col_set    = col_set_q;
    assign fire_valid = (state_q == FIRE);
    assign bad_key    = bad_key_q;

endmodule
